axis_ready_pipeline_mover: RTL and testbench

- AXI-stream register slice that pipelines the backward (ready) path. The forward-path pipeline mover registers valid/data; this block registers s_in_ready through READY_DEEP flop stages.
- A small circular skid buffer absorbs beats that are already in flight while ready propagates upstream.
- Inserted where long or high-fanout ready nets (wide sample buses, cross-floorplan links) limit timing.
- Data path is fully registered; there is no combinational path from m_out_ready to s_in_ready.

---
 rtl/axis_ready_pipeline_mover_pkg.sv | 17 +
 rtl/axis_ready_pipeline_mover_delay_line.sv | 28 ++
 rtl/axis_ready_pipeline_mover.sv | 96 +++++++++
 tb/tb_axis_ready_pipeline_mover.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_ready_pipeline_mover_pkg.sv
// Shared helpers for the ready-pipelined AXI-stream slice: pointer sizing and
// parameter legality, so that an illegal configuration stops elaboration.
package axis_ready_pipeline_mover_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Fewer than READY_DEEP+1 entries cannot absorb the beats already accepted on stale ready.
  function automatic bit params_legal(input int ready_deep, input int depth);
    return (ready_deep >= 1) && (depth >= ready_deep + 1);
  endfunction

endpackage

// File: rtl/axis_ready_pipeline_mover_delay_line.sv
// axis_ready_delay_line: STAGES-deep, reset-to-0 bit shift register for
// ready/credit paths.
module axis_ready_delay_line #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] pipe_q;

  if (STAGES == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) pipe_q[0] <= 1'b0;
      else     pipe_q[0] <= d_i;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= {pipe_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/axis_ready_pipeline_mover.sv
// AXI-stream slice with a registered ready path: a circular skid buffer soaks up
// the beats accepted while the READY_DEEP-stage ready pipe catches up.
module axis_ready_pipeline_mover
  import axis_ready_pipeline_mover_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               READY_DEEP = 1,
  parameter int               DEPTH      = 2 * READY_DEEP,
  parameter bit               DATA_INIT  = 1'b0,
  parameter logic [WIDTH-1:0] DATA_DEF   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in_valid,
  output logic             s_in_ready,
  input  logic [WIDTH-1:0] s_in_data,
  output logic             m_out_valid,
  input  logic             m_out_ready,
  output logic [WIDTH-1:0] m_out_data,
  output logic             move_valid,
  output logic             ovf
);

  localparam int PW = clog2(DEPTH);
  localparam int OW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] RDY_LIM  = OW'(DEPTH - READY_DEEP);

  if (!params_legal(READY_DEEP, DEPTH)) begin : g_bad_params
    $error("axis_ready_pipeline_mover: need READY_DEEP >= 1 and DEPTH >= READY_DEEP+1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic             ovf_q;
  logic             push, pop, full, wr_en, ready_d;

  assign full  = (occ_q == OCC_FULL);
  assign push  = s_in_valid & s_in_ready;
  assign pop   = m_out_valid & m_out_ready;
  // A push into a full buffer without a pop is dropped and flagged, never stored.
  assign wr_en = push & (~full | pop);

  always_comb begin
    occ_d = occ_q;
    if (wr_en & ~pop)      occ_d = occ_q + 1'b1;
    else if (~wr_en & pop) occ_d = occ_q - 1'b1;
  end

  assign ready_d = (occ_d <= RDY_LIM);

  axis_ready_delay_line #(
    .STAGES (READY_DEEP)
  ) u_ready_pipe (
    .clk (clk),
    .rst (rst),
    .d_i (ready_d),
    .q_o (s_in_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (wr_en) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push & full & ~pop) ovf_q <= 1'b1;
    end
  end

  if (DATA_INIT) begin : g_mem_init
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_DEF;
      end else if (wr_en) begin
        mem_q[wr_ptr_q] <= s_in_data;
      end
    end
  end else begin : g_mem_plain
    always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= s_in_data;
    end
  end

  assign m_out_valid = (occ_q != '0);
  assign m_out_data  = mem_q[rd_ptr_q];
  assign move_valid  = push;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_axis_ready_pipeline_mover.sv
// Bench for axis_ready_pipeline_mover: two configurations (L=2/D=4 with data
// init, L=3/D=5 without) share stimulus and are scored against a queue model.
module tb_axis_ready_pipeline_mover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0;
  logic       mrdy = 1'b0;
  logic [7:0] din = 8'h00;

  logic       rdy_o [2];
  logic       vld_o [2];
  logic       mv_o  [2];
  logic       ovf_o [2];
  logic [7:0] dat_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_ready_pipeline_mover #(
    .WIDTH(8), .READY_DEEP(2), .DEPTH(4), .DATA_INIT(1'b1), .DATA_DEF(8'hA5)
  ) u_a (
    .clk(clk), .rst(rst),
    .s_in_valid(vin), .s_in_ready(rdy_o[0]), .s_in_data(din),
    .m_out_valid(vld_o[0]), .m_out_ready(mrdy), .m_out_data(dat_o[0]),
    .move_valid(mv_o[0]), .ovf(ovf_o[0])
  );

  axis_ready_pipeline_mover #(
    .WIDTH(8), .READY_DEEP(3), .DEPTH(5), .DATA_INIT(1'b0), .DATA_DEF(8'h00)
  ) u_b (
    .clk(clk), .rst(rst),
    .s_in_valid(vin), .s_in_ready(rdy_o[1]), .s_in_data(din),
    .m_out_valid(vld_o[1]), .m_out_ready(mrdy), .m_out_data(dat_o[1]),
    .move_valid(mv_o[1]), .ovf(ovf_o[1])
  );

  // Reference model: FIFO contents plus a history of "room available" decisions;
  // ready seen upstream is that decision taken L cycles earlier.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         rh0[$];
  bit         rh1[$];
  bit         pushed [2];
  bit         popped [2];
  int         npop   [2];

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit rmodel(input int k);
    return (k == 0) ? rh0[0] : rh1[0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    if (k == 0) begin
      q0.delete(); rh0.delete();
      repeat (lat(0)) rh0.push_back(1'b0);
    end else begin
      q1.delete(); rh1.delete();
      repeat (lat(1)) rh1.push_back(1'b0);
    end
  endtask

  task automatic step();
    bit room;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pushed[k] = 1'b0;
      popped[k] = 1'b0;
      if (!rst) begin
        check_eq($sformatf("s_in_ready[%0d]", k), 32'(rdy_o[k]), 32'(rmodel(k)));
        check_eq($sformatf("m_out_valid[%0d]", k), 32'(vld_o[k]), 32'(qsize(k) != 0));
        if (qsize(k) != 0)
          check_eq($sformatf("m_out_data[%0d]", k), 32'(dat_o[k]), 32'(qfront(k)));
        check_eq($sformatf("move_valid[%0d]", k), 32'(mv_o[k]), 32'(vin & rmodel(k)));
        check_eq($sformatf("ovf[%0d]", k), 32'(ovf_o[k]), 32'd0);
        pushed[k] = vin & rmodel(k);
        popped[k] = (qsize(k) != 0) & mrdy;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
      end else begin
        if (popped[k]) begin
          npop[k]++;
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (pushed[k]) begin
          if (k == 0) q0.push_back(din); else q1.push_back(din);
        end
        room = (qsize(k) <= dep(k) - lat(k));
        if (k == 0) begin void'(rh0.pop_front()); rh0.push_back(room); end
        else        begin void'(rh1.pop_front()); rh1.push_back(room); end
      end
    end
    #1;
  endtask

  task automatic check_ready_after_reset(input string tag);
    // Cycle 0 is the first with rst low; sampled just after each rising edge.
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("%s_a_c%0d", tag, c), 32'(rdy_o[0]), 32'(c >= 2));
      check_eq($sformatf("%s_b_c%0d", tag, c), 32'(rdy_o[1]), 32'(c >= 3));
      step();
    end
  endtask

  initial begin
    int cnt, pops, first_push, first_pop, last_pop, acc0, acc1, drn0;
    npop[0] = 0;
    npop[1] = 0;
    model_reset(0);
    model_reset(1);

    rst = 1'b1; vin = 1'b0; mrdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_ready_after_reset("post_rst");
    check_eq("post_rst_valid_a", 32'(vld_o[0]), 32'd0);

    // Continuous stream with downstream always ready.
    cnt = 0; pops = 0; first_push = -1; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 300 && pops < 64; c++) begin
      vin = (cnt < 64);
      din = 8'(cnt);
      step();
      if (pushed[0]) begin
        if (first_push < 0) first_push = c;
        cnt++;
      end
      if (popped[0]) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
    end
    vin = 1'b0;
    check_eq("stream_pops", 32'(pops), 32'd64);
    check_eq("stream_first_latency", 32'(first_pop - first_push), 32'd1);
    check_eq("stream_back_to_back", 32'(last_pop - first_pop), 32'd63);
    repeat (8) step();

    // Fill with downstream stalled, hold, then drain.
    acc0 = 0; acc1 = 0;
    vin = 1'b1; mrdy = 1'b0;
    for (int c = 0; c < 14; c++) begin
      din = 8'($urandom);
      step();
      acc0 += int'(pushed[0]);
      acc1 += int'(pushed[1]);
    end
    vin = 1'b0;
    check_eq("fill_accepted_a", 32'(acc0), 32'd4);
    check_eq("fill_accepted_b", 32'(acc1), 32'd5);
    check_eq("fill_ready_low_a", 32'(rdy_o[0]), 32'd0);
    drn0 = 0;
    mrdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      drn0 += int'(popped[0]);
    end
    check_eq("drain_a", 32'(drn0), 32'd4);
    check_eq("drain_empty_a", 32'(vld_o[0]), 32'd0);

    // Random valid/ready until both configurations have moved 10k beats.
    npop[0] = 0;
    npop[1] = 0;
    for (int c = 0; c < 80000 && (npop[0] < 10000 || npop[1] < 10000); c++) begin
      vin  = 1'($urandom_range(1));
      mrdy = 1'($urandom_range(1));
      din  = 8'($urandom);
      step();
    end
    check_eq("random_beats_a", 32'(npop[0] >= 10000), 32'd1);
    check_eq("random_beats_b", 32'(npop[1] >= 10000), 32'd1);
    check_eq("random_ovf_a", 32'(ovf_o[0]), 32'd0);
    check_eq("random_ovf_b", 32'(ovf_o[1]), 32'd0);

    // Reset with three beats buffered.
    vin = 1'b0; mrdy = 1'b1;
    repeat (10) step();
    vin = 1'b1; mrdy = 1'b0;
    for (int c = 0; c < 20 && qsize(0) < 3; c++) begin
      din = 8'(8'h30 + c);
      step();
    end
    vin = 1'b0;
    check_eq("pre_rst_valid_a", 32'(vld_o[0]), 32'd1);
    check_eq("pre_rst_head_a", 32'(dat_o[0]), 32'h30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid_a", 32'(vld_o[0]), 32'd0);
    check_eq("mid_rst_valid_b", 32'(vld_o[1]), 32'd0);
    check_eq("mid_rst_occ_a", 32'(u_a.occ_q), 32'd0);
    check_eq("mid_rst_head_def", 32'(dat_o[0]), 32'hA5);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("mid_rst_mem_def[%0d]", i), 32'(u_a.mem_q[i]), 32'hA5);
    mrdy = 1'b1;
    check_ready_after_reset("mid_rst");
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
